// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundle of the IF-stage signals.
//   master modport : the surroundings (hazard unit, EX redirect, instruction
//                    memory) that drive stall/branch/inst and observe outputs.
//   slave modport  : the fetch stage itself.
// Signals:
//   stall, branch_taken, branch_target[31:0], inst[31:0]   -> into the stage
//   pc[31:0], id_pc[31:0], id_pc4[31:0], id_inst[31:0],
//   id_valid, misaligned_err, fetch_count[31:0]            <- out of the stage
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        misaligned_err;
  logic [31:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, inst,
    input  pc, id_pc, id_pc4, id_inst, id_valid, misaligned_err, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, inst,
    output pc, id_pc, id_pc4, id_inst, id_valid, misaligned_err, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RISC-V pipeline.
// Owns the program counter, presents it to instruction memory (which answers
// combinationally with inst), and captures {pc, inst} into the IF/ID register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_stage_if.slave (stall, redirect, inst in; pc and IF/ID out)
// Update priority on each edge: redirect > stall > sequential fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_stage_if.slave bus
);

  logic [31:0] pc_reg;
  logic [31:0] id_pc_reg;
  logic [31:0] id_pc4_reg;
  logic [31:0] id_inst_reg;
  logic        id_valid_reg;
  logic        misaligned_err_reg;
  logic [31:0] fetch_count_reg;

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg             <= RESET_PC;
      id_pc_reg          <= 32'd0;
      id_pc4_reg         <= 32'd0;
      id_inst_reg        <= NOP_INST;
      id_valid_reg       <= 1'b0;
      misaligned_err_reg <= 1'b0;
      fetch_count_reg    <= 32'd0;
    end else begin
      // Error flag is a pulse: cleared on every edge unless re-raised below.
      misaligned_err_reg <= 1'b0;
      if (bus.branch_taken) begin
        // Low address bits are dropped so pc stays word aligned; the
        // wrong-path instruction currently in IF is squashed to a bubble.
        pc_reg             <= {bus.branch_target[31:2], 2'b00};
        id_pc_reg          <= 32'd0;
        id_pc4_reg         <= 32'd0;
        id_inst_reg        <= NOP_INST;
        id_valid_reg       <= 1'b0;
        misaligned_err_reg <= (bus.branch_target[1:0] != 2'b00);
      end else if (!bus.stall) begin
        pc_reg          <= pc_plus4;
        id_pc_reg       <= pc_reg;
        id_pc4_reg      <= pc_plus4;
        id_inst_reg     <= bus.inst;
        id_valid_reg    <= 1'b1;
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
    end
  end

  assign bus.pc             = pc_reg;
  assign bus.id_pc          = id_pc_reg;
  assign bus.id_pc4         = id_pc4_reg;
  assign bus.id_inst        = id_inst_reg;
  assign bus.id_valid       = id_valid_reg;
  assign bus.misaligned_err = misaligned_err_reg;
  assign bus.fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic clk;
  logic rst_n;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: 64 words, combinational read, address wraps mod 256.
  logic [31:0] imem [0:63];
  assign bus.inst = imem[bus.pc[7:2]];

  int errors = 0;
  int checks = 0;

  // Behavioural reference state.
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_cnt;
  logic        m_valid, m_mis;

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_inst = 32'h13;
    m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock edge with the given controls; advances the reference model.
  task automatic step(input logic s, input logic bt, input logic [31:0] tgt);
    logic [31:0] fetched;
    bus.stall = s; bus.branch_taken = bt; bus.branch_target = tgt;
    fetched = imem[(m_pc / 4) % 64];
    @(posedge clk);
    m_mis = 1'b0;
    if (bt) begin
      m_pc = tgt - (tgt % 4);
      m_id_pc = 0; m_id_pc4 = 0; m_id_inst = 32'h13; m_valid = 1'b0;
      m_mis = (tgt % 4) != 0;
    end else if (!s) begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = fetched;
      m_valid = 1'b1; m_cnt = m_cnt + 1; m_pc = m_pc + 4;
    end
    #1;
    $display("txn stall=%0b br=%0b tgt=%08h -> pc=%08h id_pc=%08h id_inst=%08h v=%0b mis=%0b cnt=%0d",
             s, bt, tgt, bus.pc, bus.id_pc, bus.id_inst, bus.id_valid, bus.misaligned_err, bus.fetch_count);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%08h exp=00000000", bus.pc); end
    checks++; if (bus.id_inst !== 32'h13 || bus.id_valid !== 1'b0) begin errors++;
      $display("FAIL reset_id got inst=%08h v=%0b exp inst=00000013 v=0", bus.id_inst, bus.id_valid); end
    checks++; if (bus.fetch_count !== 0 || bus.misaligned_err !== 0 || bus.id_pc !== 0 || bus.id_pc4 !== 0) begin errors++;
      $display("FAIL reset_misc got cnt=%0d mis=%0b id_pc=%08h id_pc4=%08h exp all 0", bus.fetch_count, bus.misaligned_err, bus.id_pc, bus.id_pc4); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [0:5];
    words = '{32'hFD010113, 32'h02812623, 32'h03010413, 32'h0000B7B7, 32'hBCD78793, 32'hFEF42623};
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.pc !== 32'(4*k) || bus.id_pc !== 32'(4*(k-1)) || bus.id_pc4 !== 32'(4*k) ||
          bus.id_inst !== words[k-1] || bus.id_valid !== 1'b1 || bus.fetch_count !== 32'(k)) begin
        errors++;
        $display("FAIL seq_edge%0d got pc=%08h id_pc=%08h id_pc4=%08h inst=%08h v=%0b cnt=%0d exp pc=%08h id_pc=%08h inst=%08h v=1 cnt=%0d",
                 k, bus.pc, bus.id_pc, bus.id_pc4, bus.id_inst, bus.id_valid, bus.fetch_count, 4*k, 4*(k-1), words[k-1], k);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 32'h0);
      checks++;
      if (bus.pc !== 32'h8 || bus.id_inst !== 32'h02812623 || bus.fetch_count !== 32'd2 || bus.id_pc !== 32'h4) begin
        errors++;
        $display("FAIL stall_hold%0d got pc=%08h inst=%08h cnt=%0d id_pc=%08h exp pc=00000008 inst=02812623 cnt=2 id_pc=00000004",
                 k, bus.pc, bus.id_inst, bus.fetch_count, bus.id_pc);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.id_inst !== 32'h03010413 || bus.id_pc !== 32'h8 || bus.pc !== 32'hC || bus.fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL stall_release got inst=%08h id_pc=%08h pc=%08h cnt=%0d exp inst=03010413 id_pc=00000008 pc=0000000c cnt=3",
               bus.id_inst, bus.id_pc, bus.pc, bus.fetch_count);
    end
  endtask

  task automatic test_branch();
    step(1'b0, 1'b0, 32'h0);  // pc now 16
    step(1'b0, 1'b1, 32'h4);
    checks++;
    if (bus.pc !== 32'h4 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h13 || bus.id_pc !== 0 || bus.fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL branch_bubble got pc=%08h v=%0b inst=%08h id_pc=%08h cnt=%0d exp pc=00000004 v=0 inst=00000013 id_pc=0 cnt=4",
               bus.pc, bus.id_valid, bus.id_inst, bus.id_pc, bus.fetch_count);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.id_inst !== 32'h02812623 || bus.id_pc !== 32'h4 || bus.id_valid !== 1'b1 || bus.pc !== 32'h8) begin
      errors++;
      $display("FAIL branch_after got inst=%08h id_pc=%08h v=%0b pc=%08h exp inst=02812623 id_pc=00000004 v=1 pc=00000008",
               bus.id_inst, bus.id_pc, bus.id_valid, bus.pc);
    end
  endtask

  task automatic test_branch_over_stall();
    step(1'b1, 1'b1, 32'h10);
    checks++;
    if (bus.pc !== 32'h10 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h13 || bus.fetch_count !== 32'd5 || bus.misaligned_err !== 1'b0) begin
      errors++;
      $display("FAIL branch_stall got pc=%08h v=%0b inst=%08h cnt=%0d mis=%0b exp pc=00000010 v=0 inst=00000013 cnt=5 mis=0",
               bus.pc, bus.id_valid, bus.id_inst, bus.fetch_count, bus.misaligned_err);
    end
  endtask

  task automatic test_misaligned();
    step(1'b0, 1'b1, 32'h13);
    checks++;
    if (bus.pc !== 32'h10 || bus.misaligned_err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_set got pc=%08h mis=%0b exp pc=00000010 mis=1", bus.pc, bus.misaligned_err);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.misaligned_err !== 1'b0 || bus.pc !== 32'h14) begin
      errors++;
      $display("FAIL misaligned_clear got mis=%0b pc=%08h exp mis=0 pc=00000014", bus.misaligned_err, bus.pc);
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    checks++;
    if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redirect got pc=%08h exp fffffffc", bus.pc); end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.pc !== 32'h0 || bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0 || bus.id_inst !== imem[63]) begin
      errors++;
      $display("FAIL wrap_seq got pc=%08h id_pc=%08h id_pc4=%08h inst=%08h exp pc=0 id_pc=fffffffc id_pc4=0 inst=%08h",
               bus.pc, bus.id_pc, bus.id_pc4, bus.id_inst, imem[63]);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.pc !== 0 || bus.id_pc !== 0 || bus.id_pc4 !== 0 || bus.id_inst !== 32'h13 ||
        bus.id_valid !== 0 || bus.misaligned_err !== 0 || bus.fetch_count !== 0) begin
      errors++;
      $display("FAIL async_reset got pc=%08h id_pc=%08h id_pc4=%08h inst=%08h v=%0b mis=%0b cnt=%0d exp reset values",
               bus.pc, bus.id_pc, bus.id_pc4, bus.id_inst, bus.id_valid, bus.misaligned_err, bus.fetch_count);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pc !== 0 || bus.fetch_count !== 0) begin
      errors++; $display("FAIL async_reset_hold got pc=%08h cnt=%0d exp 0 0", bus.pc, bus.fetch_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic s, bt;
    logic [31:0] tgt;
    for (int k = 0; k < 300; k++) begin
      s  = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 7) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
      step(s, bt, tgt);
      checks++;
      if (bus.pc !== m_pc || bus.id_pc !== m_id_pc || bus.id_pc4 !== m_id_pc4 || bus.id_inst !== m_id_inst ||
          bus.id_valid !== m_valid || bus.misaligned_err !== m_mis || bus.fetch_count !== m_cnt) begin
        errors++;
        $display("FAIL random%0d got pc=%08h id_pc=%08h id_pc4=%08h inst=%08h v=%0b mis=%0b cnt=%0d exp pc=%08h id_pc=%08h id_pc4=%08h inst=%08h v=%0b mis=%0b cnt=%0d",
                 k, bus.pc, bus.id_pc, bus.id_pc4, bus.id_inst, bus.id_valid, bus.misaligned_err, bus.fetch_count,
                 m_pc, m_id_pc, m_id_pc4, m_id_inst, m_valid, m_mis, m_cnt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'hFD010113; imem[1] = 32'h02812623; imem[2] = 32'h03010413;
    imem[3] = 32'h0000B7B7; imem[4] = 32'hBCD78793; imem[5] = 32'hFEF42623;
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;

    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
